// File: rtl/tetris_pkg.sv
// Shared playfield geometry, controller state encoding and row-occupancy helper.
// The LINE_FLASH_EN build uses FLASH_CYCLES/FCNT_W for the pre-removal highlight.
package tetris_pkg;

    localparam int unsigned COLS         = 10;
    localparam int unsigned ROWS         = 30;
    localparam int unsigned GRID_W       = COLS * ROWS;
    localparam int unsigned TOP_ROWS     = 2;
    localparam int unsigned FLASH_CYCLES = 24;
    localparam int unsigned ROW_W        = $clog2(ROWS);
    localparam int unsigned IDX_W        = $clog2(GRID_W);
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned FCNT_W       = $clog2(FLASH_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FLASH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True when every cell of the given row is occupied.
    function automatic logic row_full(input logic [GRID_W-1:0] g, input logic [ROW_W-1:0] row);
        logic [IDX_W-1:0] base;
        logic [COLS-1:0]  cells;
        base  = IDX_W'(row) * IDX_W'(COLS);
        cells = g[base +: COLS];
        return &cells;
    endfunction

endpackage

// File: rtl/grid_row_shifter.sv
// Combinational row removal: rows 1..i_row take the row above, row 0 empties,
// rows below i_row pass through unchanged.
module grid_row_shifter
    import tetris_pkg::*;
(
    input  logic [GRID_W-1:0] i_grid,
    input  logic [ROW_W-1:0]  i_row,
    output logic [GRID_W-1:0] o_grid
);

    assign o_grid[0 +: COLS] = '0;

    for (genvar k = 1; k < ROWS; k++) begin : g_row
        assign o_grid[k*COLS +: COLS] = (ROW_W'(k) > i_row) ? i_grid[k*COLS +: COLS]
                                                            : i_grid[(k-1)*COLS +: COLS];
    end

endmodule

// File: rtl/grid_clear_ctrl.sv
// Playfield owner: merges locked pieces, removes full rows bottom-up, flags game over.
// Optional LINE_FLASH_EN holds each full row highlighted for FLASH_CYCLES before removal.
module grid_clear_ctrl
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              lock_valid,
    input  logic [GRID_W-1:0] lock_mask,
    output logic              lock_ready,
    output logic [GRID_W-1:0] grid,
    output logic [ROWS-1:0]   flash_rows,
    output logic              clear_done,
    output logic [CNT_W-1:0]  lines_cleared,
    output logic              collision,
    output logic              game_over
);

    state_t            r_state;
    logic [ROW_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_count;
    logic [GRID_W-1:0] r_grid;
    logic              r_lock_ready;
    logic              r_clear_done;
    logic [CNT_W-1:0]  r_lines;
    logic              r_collision;
    logic              r_game_over;
    logic [GRID_W-1:0] w_shifted;
    logic              w_top_occ;

    grid_row_shifter u_shifter (
        .i_grid (r_grid),
        .i_row  (r_row),
        .o_grid (w_shifted)
    );

    assign w_top_occ = |r_grid[TOP_ROWS*COLS-1:0];

`ifdef LINE_FLASH_EN
    logic [ROWS-1:0]   r_flash_rows;
    logic [FCNT_W-1:0] r_fcnt;
    assign flash_rows = r_flash_rows;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flash_rows <= '0;
            r_fcnt       <= '0;
        end else if (restart) begin
            r_flash_rows <= '0;
            r_fcnt       <= '0;
        end else if (r_state == ST_SCAN && row_full(r_grid, r_row)) begin
            r_flash_rows[r_row] <= 1'b1;
            r_fcnt              <= '0;
        end else if (r_state == ST_FLASH) begin
            if (r_fcnt == FCNT_W'(FLASH_CYCLES - 1)) begin
                r_flash_rows <= '0;
            end else begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end
`else
    assign flash_rows = '0;
`endif

    // Main sequencer: merge, scan/shift loop, completion reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_count      <= '0;
            r_grid       <= '0;
            r_lock_ready <= 1'b1;
            r_clear_done <= 1'b0;
            r_lines      <= '0;
            r_collision  <= 1'b0;
            r_game_over  <= 1'b0;
        end else if (restart) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_count      <= '0;
            r_grid       <= '0;
            r_lock_ready <= 1'b1;
            r_clear_done <= 1'b0;
            r_lines      <= '0;
            r_collision  <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (lock_valid && r_lock_ready) begin
                        r_grid       <= r_grid | lock_mask;
                        r_collision  <= r_collision | (|(r_grid & lock_mask));
                        r_row        <= ROW_W'(ROWS - 1);
                        r_count      <= '0;
                        r_lock_ready <= 1'b0;
                        r_state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (row_full(r_grid, r_row)) begin
`ifdef LINE_FLASH_EN
                        r_state <= ST_FLASH;
`else
                        r_state <= ST_SHIFT;
`endif
                    end else if (r_row == '0) begin
                        r_clear_done <= 1'b1;
                        r_lines      <= r_count;
                        r_game_over  <= r_game_over | w_top_occ;
                        r_state      <= ST_DONE;
                    end else begin
                        r_row <= r_row - ROW_W'(1);
                    end
                end
`ifdef LINE_FLASH_EN
                ST_FLASH: begin
                    if (r_fcnt == FCNT_W'(FLASH_CYCLES - 1)) begin
                        r_state <= ST_SHIFT;
                    end
                end
`endif
                ST_SHIFT: begin
                    // Rescan the same row index: it now holds the row from above.
                    r_grid  <= w_shifted;
                    r_count <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
                    r_state <= ST_SCAN;
                end
                ST_DONE: begin
                    r_lock_ready <= ~r_game_over;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_lock_ready <= ~r_game_over;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign lock_ready    = r_lock_ready;
    assign grid          = r_grid;
    assign clear_done    = r_clear_done;
    assign lines_cleared = r_lines;
    assign collision     = r_collision;
    assign game_over     = r_game_over;

endmodule
